// File: rtl/uart_tx_responder_if.sv
// uart_tx_responder_if: data-memory bus bundle
// Same load/store signalling as data_mem.
interface uart_tx_responder_if;
  logic        sel;
  logic [13:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [2:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;

  modport master (
    output sel,
    output addr,
    output write_data,
    output memwrite,
    output memread,
    output sign_mask,
    input  read_data,
    input  clk_stall
  );

  modport slave (
    input  sel,
    input  addr,
    input  write_data,
    input  memwrite,
    input  memread,
    input  sign_mask,
    output read_data,
    output clk_stall
  );
endinterface

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter
// Bus responder beside data_mem, TX FIFO, serialiser.
module uart_tx_responder #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd52
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_responder_if.slave bus,
  output logic               tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    B_IDLE,
    B_READ,
    B_WFULL
  } bus_st_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_st_t;

  bus_st_t       bus_q, bus_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    wbyte_q, wbyte_d;
  logic [15:0]   baud_q, baud_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  tx_st_t        tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [2:0]    bit_q, bit_d;

  logic          push, pop;
  logic [7:0]    push_data;
  logic          stall;
  logic          fifo_full, fifo_empty, busy;
  logic          a_st, a_bd, a_tx;
  logic [31:0]   status, reg_val;
  logic [15:0]   div_new;
  logic          unused_bits;

  assign unused_bits = ^{bus.sign_mask,
                         bus.addr[13:4],
                         bus.addr[1:0],
                         bus.write_data[31:16]};

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign busy       = (tx_q != IDLE);

  assign a_tx = (bus.addr[3:2] == 2'd0);
  assign a_st = (bus.addr[3:2] == 2'd1);
  assign a_bd = (bus.addr[3:2] == 2'd2);

  assign status = {24'd0, 4'(cnt_q), 1'b0,
                   fifo_empty, busy, fifo_full};

  // Load mux: TXDATA and the reserved slot read 0
  always_comb begin
    reg_val = '0;
    unique case (1'b1)
      a_st:    reg_val = status;
      a_bd:    reg_val = {16'd0, baud_q};
      default: reg_val = '0;
    endcase
  end

  // Bus FSM: one-cycle load latency, stall on full FIFO
  always_comb begin
    bus_d     = bus_q;
    rdata_d   = rdata_q;
    wbyte_d   = wbyte_q;
    baud_d    = baud_q;
    push      = 1'b0;
    push_data = bus.write_data[7:0];
    stall     = 1'b0;
    unique case (bus_q)
      B_IDLE: begin
        if (bus.sel && bus.memread) begin
          rdata_d = reg_val;
          bus_d   = B_READ;
          stall   = 1'b1;
        end else if (bus.sel && bus.memwrite) begin
          if (a_tx) begin
            if (!fifo_full) begin
              push = 1'b1;
            end else begin
              wbyte_d = bus.write_data[7:0];
              bus_d   = B_WFULL;
              stall   = 1'b1;
            end
          end else if (a_bd) begin
            baud_d = bus.write_data[15:0];
          end
        end
      end
      B_READ: begin
        bus_d = B_IDLE;
      end
      B_WFULL: begin
        stall     = 1'b1;
        push_data = wbyte_q;
        if (pop || !fifo_full) begin
          push  = 1'b1;
          bus_d = B_IDLE;
        end
      end
      default: begin
        bus_d = B_IDLE;
      end
    endcase
  end

  assign bus.clk_stall = stall;
  assign bus.read_data = rdata_q;

  // Bus-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q   <= B_IDLE;
      rdata_q <= '0;
      wbyte_q <= '0;
      baud_q  <= DEFAULT_DIV;
    end else begin
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
      wbyte_q <= wbyte_d;
      baud_q  <= baud_d;
    end
  end

  // FIFO pointer and fill-count update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // FIFO pointers; contents drop on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign div_new = (baud_q == 16'd0) ? 16'd1 : baud_q;

  // TX FSM: start, 8 data bits LSB first, stop
  always_comb begin
    tx_d    = tx_q;
    shift_d = shift_q;
    div_d   = div_q;
    bcnt_d  = bcnt_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    unique case (tx_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          div_d   = div_new;
          bcnt_d  = div_new - 16'd1;
          tx_d    = START;
        end
      end
      START: begin
        if (bcnt_q == 16'd0) begin
          bcnt_d = div_q - 16'd1;
          bit_d  = 3'd0;
          tx_d   = DATA;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bcnt_q == 16'd0) begin
          bcnt_d  = div_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bcnt_q == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            div_d   = div_new;
            bcnt_d  = div_new - 16'd1;
            tx_d    = START;
          end else begin
            tx_d = IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      default: begin
        tx_d = IDLE;
      end
    endcase
  end

  // TX-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q    <= IDLE;
      shift_q <= '0;
      div_q   <= DEFAULT_DIV;
      bcnt_q  <= '0;
      bit_q   <= '0;
    end else begin
      tx_q    <= tx_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bcnt_q  <= bcnt_d;
      bit_q   <= bit_d;
    end
  end

  assign tx_o = (tx_q == START) ? 1'b0 :
                (tx_q == DATA)  ? shift_q[0] :
                1'b1;
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: directed bench for uart_tx_responder
// Bus tasks, serial receiver, hand-computed expectations.
module tb_uart_tx_responder;
  logic clk = 1'b0;
  logic rst;
  logic tx;
  int   n_cmp = 0;
  int   n_bad = 0;

  int         mon_div;
  logic       rx_busy = 1'b0;
  int         rx_ctr = 0;
  int         rx_pos;
  logic [7:0] rx_sh = '0;
  logic [7:0] rxq [$];
  int         rx_err = 0;

  logic [31:0] d;
  logic        s0, s1;
  int          n;
  int          bad;
  logic        gs;
  logic        ok;
  logic [9:0]  f;
  int          hits [10];
  logic        ex;

  always #5 clk = ~clk;

  uart_tx_responder_if bus_if ();

  uart_tx_responder #(
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(16'd52)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus_if),
    .tx_o (tx)
  );

  assign rx_pos = rx_ctr - mon_div - mon_div / 2;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (!tx) begin
        rx_busy <= 1'b1;
        rx_ctr  <= 1;
      end
    end else begin
      rx_ctr <= rx_ctr + 1;
      if (rx_pos >= 0 && (rx_pos % mon_div) == 0) begin
        if (rx_pos / mon_div < 8) begin
          rx_sh[3'(rx_pos / mon_div)] <= tx;
        end else begin
          rxq.push_back(rx_sh);
          if (!tx) rx_err <= rx_err + 1;
          rx_busy <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.sel        = 1'b0;
    bus_if.memread    = 1'b0;
    bus_if.memwrite   = 1'b0;
    bus_if.addr       = '0;
    bus_if.write_data = '0;
    bus_if.sign_mask  = 3'b010;
  endtask

  task automatic rd(input  logic [13:0] a,
                    output logic [31:0] data,
                    output logic        s_pre,
                    output logic        s_post);
    @(negedge clk);
    bus_if.sel     = 1'b1;
    bus_if.memread = 1'b1;
    bus_if.addr    = a;
    #1 s_pre = bus_if.clk_stall;
    @(posedge clk);
    #1 data = bus_if.read_data;
    bus_idle();
    #1 s_post = bus_if.clk_stall;
    @(posedge clk);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [13:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    logic        p, q;
    rd(a, v, p, q);
    check(tag, v, exp);
  endtask

  task automatic wr(input  logic [13:0] a,
                    input  logic [31:0] data,
                    input  bit          hold,
                    output logic        s_entry,
                    output int          waits);
    @(negedge clk);
    bus_if.sel        = 1'b1;
    bus_if.memwrite   = 1'b1;
    bus_if.addr       = a;
    bus_if.write_data = data;
    #1 s_entry = bus_if.clk_stall;
    @(posedge clk);
    #1 bus_idle();
    #1;
    waits = 0;
    if (hold) begin
      while (bus_if.clk_stall && waits < 5000) begin
        @(posedge clk);
        #1 waits++;
      end
    end
  endtask

  task automatic wait_low(input string tag);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!tx) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int cnt, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rxq.size() >= cnt) break;
      @(negedge clk);
    end
    check(tag, rxq.size(), cnt);
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_idle();
    mon_div = 52;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_stall", 32'(bus_if.clk_stall), 32'd0);
    check("rst_rdata", bus_if.read_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    rd(14'h4, d, s0, s1);
    check("st_reset", d, 32'h4);
    check("rd_stall_pre", 32'(s0), 32'd1);
    check("rd_stall_post", 32'(s1), 32'd0);
    rd_chk("bd_reset", 14'h8, 32'd52);

    wr(14'hC, 32'hFFFF_FFFF, 1'b1, s0, n);
    rd_chk("rsv_rd", 14'hC, 32'd0);
    rd_chk("txd_rd", 14'h0, 32'd0);
    rd_chk("bd_keep", 14'h8, 32'd52);

    @(negedge clk);
    bus_if.sel        = 1'b1;
    bus_if.memread    = 1'b1;
    bus_if.memwrite   = 1'b1;
    bus_if.addr       = 14'h0;
    bus_if.write_data = 32'h77;
    @(posedge clk);
    #1 bus_idle();
    @(posedge clk);
    check("prio_rd", bus_if.read_data, 32'd0);
    rd_chk("prio_st", 14'h4, 32'h4);

    rxq.delete();
    wr(14'h0, 32'hA5, 1'b1, s0, n);
    wait_low("t1_start");
    foreach (hits[j]) hits[j] = 0;
    f = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 520; i++) begin
      if (i > 0) @(negedge clk);
      if (tx == f[i / 52]) hits[i / 52]++;
    end
    for (int j = 0; j < 10; j++) begin
      check($sformatf("t1_bit%0d", j), hits[j], 32'd52);
    end
    @(negedge clk);
    check("t1_idle", 32'(tx), 32'd1);
    wait_rx("t1_rxn", 1, 100);
    check("t1_rx", rx_at(0), 32'hA5);
    repeat (60) @(negedge clk);
    rd_chk("t1_st", 14'h4, 32'h4);

    rxq.delete();
    wr(14'h0, 32'h3C, 1'b1, s0, n);
    rd_chk("t3_st1", 14'h4, 32'h10);
    rd_chk("t3_st2", 14'h4, 32'h06);
    wait_rx("t3_rxn", 1, 700);
    check("t3_rx", rx_at(0), 32'h3C);
    repeat (60) @(negedge clk);

    wr(14'h8, 32'd4, 1'b1, s0, n);
    rd_chk("t2_bd", 14'h8, 32'd4);
    mon_div = 4;
    rxq.delete();
    wr(14'h0, 32'h00, 1'b1, s0, n);
    wr(14'h0, 32'hFF, 1'b1, s0, n);
    wait_low("t2_start");
    bad = 0;
    gs  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clk);
      ex = (i < 36) ? 1'b0 : (i < 40) ? 1'b1 :
           (i < 44) ? 1'b0 : 1'b1;
      if (tx !== ex) bad++;
      if (i == 40) gs = tx;
    end
    check("t2_pattern", bad, 32'd0);
    check("t2_gap", 32'(gs), 32'd0);
    @(negedge clk);
    check("t2_idle", 32'(tx), 32'd1);
    wait_rx("t2_rxn", 2, 100);
    check("t2_rx0", rx_at(0), 32'h00);
    check("t2_rx1", rx_at(1), 32'hFF);
    repeat (20) @(negedge clk);

    rxq.delete();
    for (int k = 0; k < 5; k++) begin
      wr(14'h0, 32'h11 * (k + 1), 1'b1, s0, n);
    end
    check("t4_b4_stall", 32'(s0), 32'd0);
    wr(14'h0, 32'h66, 1'b1, s0, n);
    check("t4_b5_entry", 32'(s0), 32'd1);
    check("t4_b5_wait", n, 32'd36);
    rd_chk("t4_full", 14'h4, 32'h43);
    wait_rx("t4_rxn", 6, 400);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_rx%0d", k), rx_at(k), 32'h11 * (k + 1));
    end
    repeat (20) @(negedge clk);

    wr(14'h8, 32'd0, 1'b1, s0, n);
    rd_chk("t5_bd", 14'h8, 32'd0);
    mon_div = 1;
    rxq.delete();
    wr(14'h0, 32'h5A, 1'b1, s0, n);
    wait_rx("t5_rxn", 1, 50);
    check("t5_rx", rx_at(0), 32'h5A);
    repeat (20) @(negedge clk);

    wr(14'h8, 32'd8, 1'b1, s0, n);
    mon_div = 8;
    for (int k = 0; k < 5; k++) begin
      wr(14'h0, 32'h00, 1'b1, s0, n);
    end
    wr(14'h0, 32'h00, 1'b0, s0, n);
    check("t6_entry", 32'(s0), 32'd1);
    repeat (10) @(posedge clk);
    #3;
    check("t6_pre_tx", 32'(tx), 32'd0);
    check("t6_pre_stall", 32'(bus_if.clk_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_tx", 32'(tx), 32'd1);
    check("t6_rst_stall", 32'(bus_if.clk_stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("t6_st", 14'h4, 32'h4);
    rd_chk("t6_bd", 14'h8, 32'd52);
    check("t6_tx_idle", 32'(tx), 32'd1);
    check("rx_err", rx_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
